time_set_ctrl: RTL
==================

// Module: time_set_ctrl
// PURPOSE
//  Upstream control stage for the digital clock counter chain. Debounces the TSW
//  push-switches and runs a RUN / SET_HOUR / SET_MIN editor.
//  Produces a BCD preset (HH:MM, 12-position hours 00..11) plus a one-cycle LOAD
//  strobe for the counter chain. Also produces RUN_EN (freezes seconds while
//  editing) and a digit BLINK mask for the 7-segment driver.
// PARAMETERS
//  DEB_W      16  debounce counter width; a switch must be stable 2**DEB_W pCLK cycles
//  BLINK_BIT  22  bit of the free-running counter used as the blink phase
//  TIMEOUT_W  26  idle-timeout counter width; 2**TIMEOUT_W idle cycles abort edit
// PORTS
//  pCLK    in   1  system clock, rising edge
//  nRST    in   1  asynchronous reset, active-low
//  TSW     in   8  switches, 1=pressed; [0]=MODE [1]=INC [2]=DEC [3]=CANCEL, [7:4] unused
//  CUR_H1  in   4  live hour tens (BCD, 0..1) from counter chain
//  CUR_H0  in   4  live hour units (BCD)
//  CUR_M1  in   4  live minute tens (BCD, 0..5)
//  CUR_M0  in   4  live minute units (BCD)
//  SET_H1  out  4  preset hour tens
//  SET_H0  out  4  preset hour units
//  SET_M1  out  4  preset minute tens
//  SET_M0  out  4  preset minute units
//  LOAD    out  1  one-cycle strobe: counter chain loads SET_* (seconds cleared)
//  RUN_EN  out  1  1 = timebase may advance; 0 while editing
//  BLINK   out  4  per-digit blank request [3]=H1 [2]=H0 [1]=M1 [0]=M0, 1=blank
//  MODE    out  2  00=RUN 01=SET_HOUR 10=SET_MIN 11=COMMIT
// BEHAVIOUR
//  Reset values:
//  - SET_*=0, LOAD=0, RUN_EN=1, BLINK=0, MODE=00.
//  - All debounce, edge, blink and timeout counters are cleared.
//  Input path:
//  - Each of TSW[3:0] passes a 2-FF synchroniser, then a per-bit debounce counter.
//  - The debounced level changes only after 2**DEB_W consecutive identical
//    synchronised samples; any mismatch restarts that bit's counter.
//  - A debounced 0->1 edge gives a one-cycle press pulse.
//  - Latency from a clean TSW press to its pulse: 2 + 2**DEB_W + 1 cycles.
//  - Release generates no pulse; no auto-repeat.
//  FSM:
//  - RUN: MODE pulse -> SET_HOUR, and edit regs <= CUR_*. INC, DEC, CANCEL ignored.
//  - SET_HOUR: MODE -> SET_MIN. INC/DEC step the hour.
//  - SET_MIN: MODE -> COMMIT. INC/DEC step the minute.
//  - COMMIT: LOAD=1 for exactly this cycle -> RUN. MODE=11 for that cycle.
//  - CANCEL in SET_HOUR/SET_MIN -> RUN, no LOAD, live time untouched.
//  - Idle timeout: counter clears on any press pulse. Reaching 2**TIMEOUT_W-1
//    in a set state -> RUN, no LOAD.
//  - Simultaneous pulses, priority: CANCEL > MODE > INC > DEC; one action per cycle.
//  Arithmetic (BCD-correct, no carry between hour and minute):
//  - Hour: INC 11->00, DEC 00->11; units wrap 9->0 with tens+1.
//  - Minute: INC 59->00, DEC 00->59.
//  Outputs:
//  - SET_* always drive the edit registers; they hold their value in RUN.
//  - RUN_EN = 1 only in RUN.
//  - BLINK = {2{blink_phase}},2'b00 in SET_HOUR; 2'b00,{2{blink_phase}} in SET_MIN;
//    0 in RUN and COMMIT.
//  - Blink counter free-runs in all states.
//  Reset mid-edit: immediate return to RUN, RUN_EN=1, no LOAD ever issued.
//  Out-of-range CUR_* captured (e.g. H=13): first INC/DEC re-normalises
//  (hour ->00, minute ->00); the value is passed through unchanged otherwise.
// TESTING (sim with DEB_W=2, BLINK_BIT=3, TIMEOUT_W=6)
//  - Reset, TSW=0 -> MODE=00, RUN_EN=1, LOAD=0, SET_*=0, BLINK=0 for 100 cycles.
//  - TSW[1] glitch 2 cycles high -> no state change.
//    Clean press held 10 cycles -> exactly one pulse at 2+4+1 cycles after the press.
//  - CUR=11:59, MODE, INC, MODE, INC, MODE -> LOAD one cycle, SET=00:00,
//    RUN_EN back to 1 after COMMIT.
//  - CUR=00:00, MODE, DEC -> SET_H=11. MODE, DEC -> SET_M=59. CANCEL -> MODE=00,
//    LOAD never asserted.
//  - Enter SET_HOUR, no presses for 64 cycles -> return to RUN, no LOAD.
//    BLINK[3:2] toggled every 8 cycles while in SET_HOUR.
//  - MODE+CANCEL in the same cycle in SET_MIN -> RUN, no LOAD.
//    Assert nRST during SET_MIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Switch debounce plus RUN / SET_HOUR / SET_MIN / COMMIT time editor for the clock chain.
// Emits a BCD HH:MM preset with a one-cycle LOAD strobe, RUN_EN and a per-digit blink mask.
module time_set_ctrl #(
    parameter int unsigned DEB_W     = 16,
    parameter int unsigned BLINK_BIT = 22,
    parameter int unsigned TIMEOUT_W = 26
) (
    input  logic       pCLK,
    input  logic       nRST,
    input  logic [7:0] TSW,
    input  logic [3:0] CUR_H1,
    input  logic [3:0] CUR_H0,
    input  logic [3:0] CUR_M1,
    input  logic [3:0] CUR_M0,
    output logic [3:0] SET_H1,
    output logic [3:0] SET_H0,
    output logic [3:0] SET_M1,
    output logic [3:0] SET_M0,
    output logic       LOAD,
    output logic       RUN_EN,
    output logic [3:0] BLINK,
    output logic [1:0] MODE
);

    localparam int unsigned NSW = 4;
    localparam logic [DEB_W-1:0]     DEB_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_COMMIT   = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [NSW-1:0]       sync1_q, sync2_q;
    logic [NSW-1:0]       deb_q, deb_d, deb_dly_q;
    logic [DEB_W-1:0]     deb_cnt_q [NSW];
    logic [DEB_W-1:0]     deb_cnt_d [NSW];
    logic [NSW-1:0]       press_q, press_d;
    logic [BLINK_BIT:0]   blink_cnt_q, blink_cnt_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [3:0]           h1_q, h0_q, m1_q, m0_q;
    logic [3:0]           h1_d, h0_d, m1_d, m0_d;
    logic                 load_q, load_d;
    logic                 run_en_q, run_en_d;
    logic [3:0]           blink_q, blink_d;
    logic                 p_mode, p_inc, p_dec, p_cancel;
    logic                 unused_tsw;

    assign unused_tsw = ^TSW[7:4];

    assign p_mode   = press_q[0];
    assign p_inc    = press_q[1];
    assign p_dec    = press_q[2];
    assign p_cancel = press_q[3];

    function automatic logic hour_ok(input logic [3:0] t, input logic [3:0] u);
        return ((t == 4'd0) && (u <= 4'd9)) || ((t == 4'd1) && (u <= 4'd1));
    endfunction

    function automatic logic min_ok(input logic [3:0] t, input logic [3:0] u);
        return (t <= 4'd5) && (u <= 4'd9);
    endfunction

    // Out-of-range captured values snap to 00 on the first step
    function automatic logic [7:0] hour_inc(input logic [3:0] t, input logic [3:0] u);
        if (!hour_ok(t, u) || ((t == 4'd1) && (u == 4'd1))) return 8'h00;
        else if (u == 4'd9)                                 return {4'(t + 4'd1), 4'd0};
        else                                                return {t, 4'(u + 4'd1)};
    endfunction

    function automatic logic [7:0] hour_dec(input logic [3:0] t, input logic [3:0] u);
        if (!hour_ok(t, u))                    return 8'h00;
        else if ((t == 4'd0) && (u == 4'd0))   return 8'h11;
        else if (u == 4'd0)                    return {4'(t - 4'd1), 4'd9};
        else                                   return {t, 4'(u - 4'd1)};
    endfunction

    function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
        if (!min_ok(t, u) || ((t == 4'd5) && (u == 4'd9))) return 8'h00;
        else if (u == 4'd9)                                 return {4'(t + 4'd1), 4'd0};
        else                                                return {t, 4'(u + 4'd1)};
    endfunction

    function automatic logic [7:0] min_dec(input logic [3:0] t, input logic [3:0] u);
        if (!min_ok(t, u))                     return 8'h00;
        else if ((t == 4'd0) && (u == 4'd0))   return 8'h59;
        else if (u == 4'd0)                    return {4'(t - 4'd1), 4'd9};
        else                                   return {t, 4'(u - 4'd1)};
    endfunction

    // Debounce: level flips after 2**DEB_W consecutive differing samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NSW; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_MAX) deb_d[i] = sync2_q[i];
                else                         deb_cnt_d[i] = DEB_W'(deb_cnt_q[i] + 1'b1);
            end
        end
        press_d     = deb_q & ~deb_dly_q;
        blink_cnt_d = (BLINK_BIT + 1)'(blink_cnt_q + 1'b1);
    end

    // Editor next state, edit registers and registered outputs
    always_comb begin
        state_d = state_q;
        h1_d    = h1_q;
        h0_d    = h0_q;
        m1_d    = m1_q;
        m0_d    = m0_q;
        tmo_d   = '0;
        if ((state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN))
            tmo_d = (press_q != '0) ? '0 : TIMEOUT_W'(tmo_q + 1'b1);

        case (state_q)
            ST_RUN: begin
                if (p_mode) begin
                    state_d = ST_SET_HOUR;
                    h1_d    = CUR_H1;
                    h0_d    = CUR_H0;
                    m1_d    = CUR_M1;
                    m0_d    = CUR_M0;
                end
            end
            ST_SET_HOUR: begin
                if (p_cancel)              state_d = ST_RUN;
                else if (p_mode)           state_d = ST_SET_MIN;
                else if (p_inc)            {h1_d, h0_d} = hour_inc(h1_q, h0_q);
                else if (p_dec)            {h1_d, h0_d} = hour_dec(h1_q, h0_q);
                else if (tmo_q == TMO_MAX) state_d = ST_RUN;
            end
            ST_SET_MIN: begin
                if (p_cancel)              state_d = ST_RUN;
                else if (p_mode)           state_d = ST_COMMIT;
                else if (p_inc)            {m1_d, m0_d} = min_inc(m1_q, m0_q);
                else if (p_dec)            {m1_d, m0_d} = min_dec(m1_q, m0_q);
                else if (tmo_q == TMO_MAX) state_d = ST_RUN;
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        load_d   = (state_d == ST_COMMIT);
        run_en_d = (state_d == ST_RUN);
        case (state_d)
            ST_SET_HOUR: blink_d = {{2{blink_cnt_d[BLINK_BIT]}}, 2'b00};
            ST_SET_MIN:  blink_d = {2'b00, {2{blink_cnt_d[BLINK_BIT]}}};
            default:     blink_d = 4'b0000;
        endcase
    end

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_RUN;
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_dly_q   <= '0;
            press_q     <= '0;
            for (int i = 0; i < NSW; i++) deb_cnt_q[i] <= '0;
            blink_cnt_q <= '0;
            tmo_q       <= '0;
            h1_q        <= '0;
            h0_q        <= '0;
            m1_q        <= '0;
            m0_q        <= '0;
            load_q      <= 1'b0;
            run_en_q    <= 1'b1;
            blink_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= TSW[NSW-1:0];
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_dly_q   <= deb_q;
            press_q     <= press_d;
            for (int i = 0; i < NSW; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            blink_cnt_q <= blink_cnt_d;
            tmo_q       <= tmo_d;
            h1_q        <= h1_d;
            h0_q        <= h0_d;
            m1_q        <= m1_d;
            m0_q        <= m0_d;
            load_q      <= load_d;
            run_en_q    <= run_en_d;
            blink_q     <= blink_d;
        end
    end

    assign SET_H1 = h1_q;
    assign SET_H0 = h0_q;
    assign SET_M1 = m1_q;
    assign SET_M0 = m0_q;
    assign LOAD   = load_q;
    assign RUN_EN = run_en_q;
    assign BLINK  = blink_q;
    assign MODE   = state_q;

endmodule
